// File: rtl/fillrect_pkg.sv
// rtl/fillrect_pkg.sv - shared types, screen defaults and per-pixel colour rule for the fill engines
//
// Contents:
//   DEF_SCREEN_W / DEF_SCREEN_H  default frame-buffer size, shared with the other drawing engines
//   fill_mode_t                  colour mode selector (SOLID, XSTRIPE, YSTRIPE, CHECKER)
//   state_t                      engine FSM states
//   fill_colour()                colour of one pixel from mode, base colour and coordinates
package fillrect_pkg;

  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;

  // fill_colour works on fixed, generously wide operands; callers zero-extend
  // their fields in and truncate the result to their own colour width, which
  // gives the mod 2^CW wrap for the stripe modes for free.
  localparam int COL_MAX_W = 8;
  localparam int CRD_MAX_W = 16;

  typedef enum logic [1:0] {
    SOLID   = 2'd0,
    XSTRIPE = 2'd1,
    YSTRIPE = 2'd2,
    CHECKER = 2'd3
  } fill_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PLOT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [COL_MAX_W-1:0] fill_colour(
    input fill_mode_t             mode,
    input logic [COL_MAX_W-1:0]   colour,
    input logic [CRD_MAX_W-1:0]   x,
    input logic [CRD_MAX_W-1:0]   y
  );
    logic [CRD_MAX_W-1:0] sum;
    sum         = '0;
    fill_colour = colour;
    case (mode)
      XSTRIPE: begin
        sum         = {{(CRD_MAX_W-COL_MAX_W){1'b0}}, colour} + x;
        fill_colour = sum[COL_MAX_W-1:0];
      end
      YSTRIPE: begin
        sum         = {{(CRD_MAX_W-COL_MAX_W){1'b0}}, colour} + y;
        fill_colour = sum[COL_MAX_W-1:0];
      end
      CHECKER: begin
        if (x[0] ^ y[0]) fill_colour = ~colour;
      end
      default: fill_colour = colour;
    endcase
  endfunction

endpackage

// File: rtl/fillrect_if.sv
// rtl/fillrect_if.sv - request/plot bundle between the control FSM, the fill engine and the VGA plot port
//
// Signals:
//   start       requester -> engine  request, held high until done is seen
//   mode        requester -> engine  colour mode (fill_mode_t)
//   colour      requester -> engine  base colour, CW bits
//   x0, y0      requester -> engine  rectangle top-left corner
//   w, h        requester -> engine  rectangle size, XW+1 / YW+1 bits, 0 legal
//   done        engine -> requester  operation complete
//   busy        engine -> requester  engine is in SETUP or PLOT
//   vga_x/y     engine -> VGA        pixel coordinate
//   vga_colour  engine -> VGA        pixel colour
//   vga_plot    engine -> VGA        write strobe
// Modports: master (requester side), slave (engine side).
interface fillrect_if
  import fillrect_pkg::*;
#(
  parameter int XW = 8,
  parameter int YW = 7,
  parameter int CW = 3
) ();

  logic          start;
  fill_mode_t    mode;
  logic [CW-1:0] colour;
  logic [XW-1:0] x0;
  logic [YW-1:0] y0;
  logic [XW:0]   w;
  logic [YW:0]   h;
  logic          done;
  logic          busy;
  logic [XW-1:0] vga_x;
  logic [YW-1:0] vga_y;
  logic [CW-1:0] vga_colour;
  logic          vga_plot;

  modport master (
    output start, mode, colour, x0, y0, w, h,
    input  done, busy, vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    input  start, mode, colour, x0, y0, w, h,
    output done, busy, vga_x, vga_y, vga_colour, vga_plot
  );

endinterface

// File: rtl/fillrect_clip.sv
// rtl/fillrect_clip.sv - clips a rectangle to the screen and flags rectangles with nothing to draw
//
// Ports:
//   i_x0, i_y0  rectangle top-left corner
//   i_w, i_h    rectangle size (XW+1 / YW+1 bits)
//   o_xe, o_ye  last column / row to plot, clipped to SCREEN_W-1 / SCREEN_H-1
//   o_empty     rectangle has zero size or starts off-screen; o_xe/o_ye are meaningless then
module fillrect_clip
  import fillrect_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int XW       = 8,
  parameter int YW       = 7
) (
  input  logic [XW-1:0] i_x0,
  input  logic [YW-1:0] i_y0,
  input  logic [XW:0]   i_w,
  input  logic [YW:0]   i_h,
  output logic [XW-1:0] o_xe,
  output logic [YW-1:0] o_ye,
  output logic          o_empty
);

  // One bit wider than the size fields: x0 + w - 1 can exceed 2^(XW+1)-1
  // when both are near their maximum, and the sum must never wrap back on-screen.
  localparam logic [XW+1:0] XMAX = (XW+2)'(SCREEN_W - 1);
  localparam logic [YW+1:0] YMAX = (YW+2)'(SCREEN_H - 1);

  logic [XW+1:0] w_xend;
  logic [YW+1:0] w_yend;

  // Underflows when the size is zero, but o_empty covers that case.
  assign w_xend = {2'b00, i_x0} + {1'b0, i_w} - (XW+2)'(1);
  assign w_yend = {2'b00, i_y0} + {1'b0, i_h} - (YW+2)'(1);

  assign o_xe = (w_xend > XMAX) ? XMAX[XW-1:0] : w_xend[XW-1:0];
  assign o_ye = (w_yend > YMAX) ? YMAX[YW-1:0] : w_yend[YW-1:0];

  assign o_empty = (i_w == '0) || (i_h == '0) ||
                   ({2'b00, i_x0} > XMAX) || ({2'b00, i_y0} > YMAX);

endmodule

// File: rtl/fillrect_engine.sv
// rtl/fillrect_engine.sv - fills a screen-clipped rectangle of the frame buffer, one pixel per clock
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    fillrect_if.slave: start/mode/colour/x0/y0/w/h in; done/busy/vga_* out
//
// Every output is a register loaded from the current state, so outputs trail
// the FSM by one cycle: busy covers SETUP..last PLOT cycle, the last pixel is
// strobed in the first DONE cycle, and done rises the cycle after that.
module fillrect_engine
  import fillrect_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int XW       = 8,
  parameter int YW       = 7,
  parameter int CW       = 3
) (
  input  logic      clk,
  input  logic      rst_n,
  fillrect_if.slave bus
);

  state_t        r_state;
  state_t        w_state_nxt;

  // Request latched in IDLE; held for the whole operation.
  fill_mode_t    r_mode;
  logic [CW-1:0] r_colour;
  logic [XW-1:0] r_x0;
  logic [YW-1:0] r_y0;
  logic [XW:0]   r_w;
  logic [YW:0]   r_h;

  // Clipped far corner and scan position.
  logic [XW-1:0] r_xe;
  logic [YW-1:0] r_ye;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;

  logic [XW-1:0] w_xe;
  logic [YW-1:0] w_ye;
  logic          w_empty;
  logic          w_last;
  logic [CW-1:0] w_pix_colour;

  logic          w_busy_nxt;
  logic          w_plot_nxt;
  logic          w_done_nxt;

  logic          r_done;
  logic          r_busy;
  logic          r_vga_plot;
  logic [XW-1:0] r_vga_x;
  logic [YW-1:0] r_vga_y;
  logic [CW-1:0] r_vga_colour;

  fillrect_clip #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H),
    .XW       (XW),
    .YW       (YW)
  ) u_clip (
    .i_x0    (r_x0),
    .i_y0    (r_y0),
    .i_w     (r_w),
    .i_h     (r_h),
    .o_xe    (w_xe),
    .o_ye    (w_ye),
    .o_empty (w_empty)
  );

  assign w_last       = (r_x == r_xe) && (r_y == r_ye);
  assign w_pix_colour = CW'(fill_colour(r_mode, COL_MAX_W'(r_colour),
                                        CRD_MAX_W'(r_x), CRD_MAX_W'(r_y)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy_nxt  = 1'b0;
    w_plot_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) w_state_nxt = SETUP;
      end
      SETUP: begin
        w_busy_nxt  = 1'b1;
        w_state_nxt = w_empty ? DONE : PLOT;
      end
      PLOT: begin
        w_busy_nxt = 1'b1;
        w_plot_nxt = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        // First DONE cycle always raises done, so a requester that let go of
        // start early still gets a one-cycle pulse. After that done tracks
        // start, so it falls on the same edge that returns us to IDLE.
        w_done_nxt = bus.start || !r_done;
        if (!bus.start) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode   <= SOLID;
      r_colour <= '0;
      r_x0     <= '0;
      r_y0     <= '0;
      r_w      <= '0;
      r_h      <= '0;
      r_xe     <= '0;
      r_ye     <= '0;
      r_x      <= '0;
      r_y      <= '0;
    end else begin
      if (r_state == IDLE && bus.start) begin
        r_mode   <= bus.mode;
        r_colour <= bus.colour;
        r_x0     <= bus.x0;
        r_y0     <= bus.y0;
        r_w      <= bus.w;
        r_h      <= bus.h;
      end
      if (r_state == SETUP) begin
        r_xe <= w_xe;
        r_ye <= w_ye;
        r_x  <= r_x0;
        r_y  <= r_y0;
      end
      // Column-major scan: walk down a column, then step right.
      if (r_state == PLOT) begin
        if (r_y == r_ye) begin
          r_y <= r_y0;
          r_x <= r_x + XW'(1);
        end else begin
          r_y <= r_y + YW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
      r_vga_plot   <= 1'b0;
      r_vga_x      <= '0;
      r_vga_y      <= '0;
      r_vga_colour <= '0;
    end else begin
      r_done     <= w_done_nxt;
      r_busy     <= w_busy_nxt;
      r_vga_plot <= w_plot_nxt;
      if (w_plot_nxt) begin
        r_vga_x      <= r_x;
        r_vga_y      <= r_y;
        r_vga_colour <= w_pix_colour;
      end
    end
  end

  assign bus.done       = r_done;
  assign bus.busy       = r_busy;
  assign bus.vga_plot   = r_vga_plot;
  assign bus.vga_x      = r_vga_x;
  assign bus.vga_y      = r_vga_y;
  assign bus.vga_colour = r_vga_colour;

endmodule

// File: tb/tb_fillrect_engine.sv
// tb/tb_fillrect_engine.sv - self-checking bench for fillrect_engine
module tb_fillrect_engine;
  import fillrect_pkg::*;

  localparam int W  = 160;
  localparam int H  = 120;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  fillrect_if #(.XW(XW), .YW(YW), .CW(CW)) bus ();

  fillrect_engine #(
    .SCREEN_W (W),
    .SCREEN_H (H),
    .XW       (XW),
    .YW       (YW),
    .CW       (CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int x;
    int y;
    int c;
  } pix_t;

  typedef struct {
    int mode, colour, x0, y0, w, h;
    int npix;
    int fx, fy, fc;
    int lx, ly, lc;
    int hold, early;
  } vec_t;

  pix_t plot_q[$];
  pix_t exp_q[$];
  int   busy_cnt = 0;
  int   oob_cnt  = 0;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always @(negedge clk) begin
    if (bus.vga_plot === 1'b1) begin
      plot_q.push_back('{int'(bus.vga_x), int'(bus.vga_y), int'(bus.vga_colour)});
      if (int'(bus.vga_x) >= W || int'(bus.vga_y) >= H) oob_cnt++;
    end
    if (bus.busy === 1'b1) busy_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int ref_colour(int mode, int colour, int x, int y);
    int m = 1 << CW;
    case (mode)
      0:       return colour;
      1:       return (colour + x) % m;
      2:       return (colour + y) % m;
      default: return ((x % 2) == (y % 2)) ? colour : (m - 1) - colour;
    endcase
  endfunction

  // Reference: every on-screen pixel of the rectangle, columns left to right,
  // each column top to bottom.
  task automatic build_exp(input int mode, colour, x0, y0, w, h);
    int xe, ye;
    exp_q.delete();
    if (w == 0 || h == 0 || x0 >= W || y0 >= H) return;
    xe = (x0 + w - 1 > W - 1) ? W - 1 : x0 + w - 1;
    ye = (y0 + h - 1 > H - 1) ? H - 1 : y0 + h - 1;
    for (int x = x0; x <= xe; x++)
      for (int y = y0; y <= ye; y++)
        exp_q.push_back('{x, y, ref_colour(mode, colour, x, y)});
  endtask

  task automatic check_seq(input string name);
    int bad = -1;
    int n   = (exp_q.size() < plot_q.size()) ? exp_q.size() : plot_q.size();
    tests_run++;
    for (int i = 0; i < n; i++)
      if (bad < 0 && (plot_q[i].x != exp_q[i].x || plot_q[i].y != exp_q[i].y ||
                      plot_q[i].c != exp_q[i].c)) bad = i;
    if (bad >= 0) begin
      tests_failed++;
      $display("FAIL %s seq: pixel %0d got (%0d,%0d)=%0d expected (%0d,%0d)=%0d", name, bad,
               plot_q[bad].x, plot_q[bad].y, plot_q[bad].c, exp_q[bad].x, exp_q[bad].y, exp_q[bad].c);
    end else if (plot_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL %s seq: got %0d plots expected %0d", name, plot_q.size(), exp_q.size());
    end
  endtask

  // One full request/done handshake. hold: extra cycles start stays high after
  // done; early: start is dropped right after it has been sampled.
  task automatic run_op(input string name, input int mode, colour, x0, y0, w, h,
                        input int hold, input int early);
    int npix, cyc, n;
    bit held_ok;
    build_exp(mode, colour, x0, y0, w, h);
    npix = exp_q.size();
    @(negedge clk);
    plot_q.delete();
    busy_cnt   = 0;
    oob_cnt    = 0;
    bus.mode   = fill_mode_t'(mode);
    bus.colour = CW'(colour);
    bus.x0     = XW'(x0);
    bus.y0     = YW'(y0);
    bus.w      = (XW+1)'(w);
    bus.h      = (YW+1)'(h);
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    if (early != 0) bus.start = 1'b0;
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < npix + 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({name, " latency"}, cyc, npix + 2);
    if (early == 0) begin
      n       = plot_q.size();
      held_ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        if (bus.done !== 1'b1) held_ok = 1'b0;
      end
      if (hold > 0) begin
        check({name, " done held"}, held_ok, 1);
        check({name, " no extra plots"}, plot_q.size(), n);
      end
      bus.start = 1'b0;
    end
    @(posedge clk);
    #1;
    check({name, " done fall"}, bus.done, 0);
    check({name, " plot count"}, plot_q.size(), npix);
    check({name, " busy cycles"}, busy_cnt, npix + 1);
    check({name, " off-screen"}, oob_cnt, 0);
    check_seq(name);
  endtask

  vec_t vecs[11];

  initial begin
    int k, n;

    //                mode col x0   y0   w    h    npix   fx   fy   fc  lx   ly   lc hold early
    vecs[0]  = '{0, 5,   0,   0, 160, 120, 19200,   0,   0, 5, 159, 119, 5,  0, 0};
    vecs[1]  = '{0, 2, 150, 110,  20,  20,   100, 150, 110, 2, 159, 119, 2, 50, 0};
    vecs[2]  = '{0, 4,  10,  10,   0,   5,     0,   0,   0, 0,   0,   0, 0,  0, 1};
    vecs[3]  = '{0, 4, 200,  10,   5,   5,     0,   0,   0, 0,   0,   0, 0,  0, 0};
    vecs[4]  = '{1, 3,   5,   0,   3,   2,     6,   5,   0, 0,   7,   1, 2,  0, 0};
    vecs[5]  = '{3, 1,   0,   0,   2,   2,     4,   0,   0, 1,   1,   1, 1,  2, 0};
    vecs[6]  = '{2, 6,  10,   3,   2,   4,     8,  10,   3, 1,  11,   6, 4,  0, 1};
    vecs[7]  = '{0, 7, 159, 119, 511, 255,     1, 159, 119, 7, 159, 119, 7,  0, 0};
    vecs[8]  = '{3, 2,   3,   4,   3,   1,     3,   3,   4, 5,   5,   4, 5,  0, 0};
    vecs[9]  = '{0, 1,  20, 125,   4,   4,     0,   0,   0, 0,   0,   0, 0,  0, 0};
    vecs[10] = '{1, 7, 158,   0,   5,   1,     2, 158,   0, 5, 159,   0, 6,  0, 0};

    bus.start  = 1'b0;
    bus.mode   = SOLID;
    bus.colour = '0;
    bus.x0     = '0;
    bus.y0     = '0;
    bus.w      = '0;
    bus.h      = '0;

    // Reset must act before any clock edge.
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("reset done", bus.done, 0);
    check("reset busy", bus.busy, 0);
    check("reset plot", bus.vga_plot, 0);
    check("reset xy", {bus.vga_x, bus.vga_y}, 0);
    check("reset colour", bus.vga_colour, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      run_op(nm, vecs[i].mode, vecs[i].colour, vecs[i].x0, vecs[i].y0, vecs[i].w, vecs[i].h,
             vecs[i].hold, vecs[i].early);
      check({nm, " table npix"}, plot_q.size(), vecs[i].npix);
      if (vecs[i].npix > 0 && plot_q.size() > 0) begin
        check({nm, " first pixel"}, {plot_q[0].x, plot_q[0].y, plot_q[0].c},
              {vecs[i].fx, vecs[i].fy, vecs[i].fc});
        check({nm, " last pixel"}, {plot_q[$].x, plot_q[$].y, plot_q[$].c},
              {vecs[i].lx, vecs[i].ly, vecs[i].lc});
      end
    end
    // Full-screen second pixel steps down the first column.
    // (vec0 sequence was already compared in full above.)

    // Asynchronous reset in the middle of a fill.
    @(negedge clk);
    plot_q.delete();
    bus.mode   = SOLID;
    bus.colour = 3'd3;
    bus.x0     = '0;
    bus.y0     = '0;
    bus.w      = 9'd20;
    bus.h      = 8'd20;
    bus.start  = 1'b1;
    k = 0;
    while (plot_q.size() < 10 && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("rst plots reached", plot_q.size() >= 10, 1);
    rst_n = 1'b0;
    #1;
    check("rst mid plot", bus.vga_plot, 0);
    check("rst mid busy", bus.busy, 0);
    check("rst mid done", bus.done, 0);
    bus.start = 1'b0;
    n = plot_q.size();
    repeat (3) @(posedge clk);
    #1;
    check("rst no plots", plot_q.size(), n);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after rst", 3, 6, 7, 9, 4, 3, 1, 0);

    // Randomised requests against the reference model.
    for (int i = 0; i < 30; i++) begin
      int m, c, x0, y0, w, h, hold, early;
      m     = int'($urandom_range(0, 3));
      c     = int'($urandom_range(0, 7));
      x0    = int'($urandom_range(0, 175));
      y0    = int'($urandom_range(0, 127));
      w     = int'($urandom_range(0, 40));
      h     = int'($urandom_range(0, 40));
      hold  = int'($urandom_range(0, 3));
      early = int'($urandom_range(0, 1));
      run_op($sformatf("rnd%0d", i), m, c, x0, y0, w, h, hold, early);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fillrect_engine.md
Name: fillrect_engine

Overview:
- Parametrised successor to the full-screen fill block. Fills any axis-aligned rectangle of the VGA frame buffer, one pixel per clock, clipped to the screen.
- Supports four colour modes and uses the same start/done handshake as the other drawing engines.
- Sits between the top-level control FSM and the vga_adapter plot port; it is muxed with the circle and Reuleaux engines.

Parameters:
- SCREEN_W, 160, screen width in pixels.
- SCREEN_H, 120, screen height in pixels.
- XW, 8, x coordinate width; must satisfy 2^XW >= SCREEN_W.
- YW, 7, y coordinate width; must satisfy 2^YW >= SCREEN_H.
- CW, 3, colour width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; level held high by the requester until done is seen.
- mode  in  2  colour mode: 0 SOLID, 1 XSTRIPE, 2 YSTRIPE, 3 CHECKER.
- colour  in  CW  base colour.
- x0  in  XW  rectangle left edge.
- y0  in  YW  rectangle top edge.
- w  in  XW+1  width in pixels; 0 is legal.
- h  in  YW+1  height in pixels; 0 is legal.
- done  out  1  operation complete.
- busy  out  1  high in SETUP and PLOT.
- vga_x  out  XW  pixel x.
- vga_y  out  YW  pixel y.
- vga_colour  out  CW  pixel colour.
- vga_plot  out  1  write strobe, one pixel per cycle.

Behaviour:
- Reset (async, rst_n=0): state IDLE. done=0, busy=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0, all immediately. Reset mid-PLOT aborts with no further plots.
- All outputs are registered.
- States: IDLE, SETUP, PLOT, DONE.
- IDLE: on a rising clk edge with start=1, latch mode, colour, x0, y0, w, h and go to SETUP. Inputs are not re-sampled until the next IDLE.
- SETUP (1 cycle):
  - Compute xe = min(x0+w-1, SCREEN_W-1) and ye = min(y0+h-1, SCREEN_H-1), using XW+1 and YW+1 bit arithmetic with no wrap.
  - Empty if w==0, h==0, x0>=SCREEN_W or y0>=SCREEN_H. Empty goes to DONE with zero plots; otherwise load x=x0, y=y0 and go to PLOT.
- PLOT:
  - vga_plot=1 every cycle with the current (x, y) and its colour.
  - Scan order: x outer, y inner. y increments to ye, then y=y0 and x++. After (xe, ye) is plotted, go to DONE.
  - Exactly npix = (xe-x0+1)*(ye-y0+1) plot cycles, with no gaps or duplicates.
- Colour per pixel:
  - SOLID: colour.
  - XSTRIPE: (colour + x) mod 2^CW.
  - YSTRIPE: (colour + y) mod 2^CW.
  - CHECKER: colour if (x[0]^y[0])==0, else ~colour.
- DONE: done=1, vga_plot=0. Stays in DONE while start=1. When start=0, go to IDLE; done falls on that edge.
- Latency: done is first high npix+2 rising edges after the edge that samples start.
- Start deasserted early (during SETUP or PLOT) is ignored; the fill completes. In that case done is high for exactly one cycle.
- start=1 in IDLE right after DONE begins a new operation. There is no retrigger without an intervening start=0.
- busy = (state==SETUP || state==PLOT).

Decomposition:
- Package fillrect_pkg holds:
  - enum fill_mode_t {SOLID, XSTRIPE, YSTRIPE, CHECKER};
  - enum state_t {IDLE, SETUP, PLOT, DONE};
  - default SCREEN_W/SCREEN_H localparams, shared with the other engines.
- One combinational sub-module, fillrect_clip: inputs x0, y0, w, h; outputs xe, ye, empty. It is parametrised identically and unit-testable alone.
- Colour generation is a function in fillrect_pkg.

Test Plan:
1. Full screen: SOLID, colour=5, x0=0, y0=0, w=160, h=120.
   - 19200 plots; first (0,0), second (0,1), last (159,119), all colour 5.
   - done high at edge 19202; no coordinate outside the screen.
2. Clipped: x0=150, y0=110, w=20, h=20.
   - 100 plots covering x 150..159, y 110..119; no plot at x>=160 or y>=120.
3. Empty cases: w=0; and separately x0=200, w=5, h=5.
   - Zero vga_plot pulses; done high at edge 2; busy high for exactly 1 cycle.
4. XSTRIPE: colour=3, x0=5, y0=0, w=3, h=2.
   - Plots (5,0)=0, (5,1)=0, (6,0)=1, (6,1)=1, (7,0)=2, (7,1)=2.
   - CHECKER: colour=1, 2x2 at (0,0) gives 1, 6, 6, 1.
5. Async reset mid-PLOT: assert rst_n=0 between clock edges after 10 plots.
   - vga_plot, done and busy drop immediately; after release, a new start completes normally.
6. Handshake:
   - start held 50 cycles past done: done stays 1 with no extra plots; start=0 makes done=0 at the next edge.
   - start dropped during PLOT: done pulses exactly 1 cycle.
